// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator subsystem.
//   state_t : car-level controller states (IDLE, UP, DOWN, DOOR)
//   dir_t   : scan direction encoding, DIR_UP drives dir_up high
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DOOR = 2'd3
  } state_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

endpackage : elevator_pkg

// File: rtl/elevator_req_scan.sv
// Combinational request scanner.
// Reports whether any pending request lies strictly above or strictly below
// a given floor, by masking the pending bitmap with per-floor compare masks.
//   pending_i : outstanding request bitmap, one bit per floor
//   floor_i   : reference floor
//   above_o   : some pending bit at an index greater than floor_i
//   below_o   : some pending bit at an index less than floor_i
module elevator_req_scan #(
  parameter int NUM_FLOORS = 8,
  localparam int FLOOR_W = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    floor_i,
  output logic                  above_o,
  output logic                  below_o
);

  logic [NUM_FLOORS-1:0] above_mask;
  logic [NUM_FLOORS-1:0] below_mask;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_mask[i] = (i > int'(floor_i));
      below_mask[i] = (i < int'(floor_i));
    end
  end

  assign above_o = |(pending_i & above_mask);
  assign below_o = |(pending_i & below_mask);

endmodule : elevator_req_scan

// File: rtl/elevator_scan_ctrl.sv
// Car-level elevator controller with SCAN scheduling.
// Requests are latched into a pending bitmap; the car keeps moving in its
// current direction while requests remain ahead, then reverses. Each floor
// of travel takes TRAVEL_CYCLES cycles; each stop holds the door open for
// DOOR_CYCLES cycles, restarted by a request for the current floor.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   req_valid  : request strobe, sampled every rising edge
//   req_floor  : requested floor, ignored when out of range
//   cur_floor  : floor the car is at or last passed
//   dir_up     : scan direction (1 = up)
//   moving     : car travelling (UP/DOWN)
//   door_open  : door open (DOOR)
//   arrive     : one-cycle pulse in the first door-open cycle of each stop
//   pending    : outstanding request bitmap
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8,
  localparam int FLOOR_W = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DOOR_W   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);

  state_t                state_q, state_d;
  dir_t                  dir_q, dir_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [TRAVEL_W-1:0]   travel_q, travel_d;
  logic [DOOR_W-1:0]     door_q, door_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic                  moving_q, door_open_q, arrive_q;

  logic [NUM_FLOORS-1:0] set_vec, clr_vec;
  logic [FLOOR_W-1:0]    next_floor;
  logic                  req_ok, req_cur_door;
  logic                  hit_cur, hit_next, going_up;
  logic                  above_cur, below_cur, above_nxt, below_nxt;

  // One-hot bit for a floor index; loop compare keeps every index in range
  // even when NUM_FLOORS is not a power of two.
  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (int'(f) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Floor the car reaches when the current travel leg completes.
  always_comb begin
    next_floor = floor_q;
    if (state_q == ST_UP)   next_floor = floor_q + FLOOR_W'(1);
    if (state_q == ST_DOWN) next_floor = floor_q - FLOOR_W'(1);
  end

  elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan_cur (
    .pending_i (pending_q),
    .floor_i   (floor_q),
    .above_o   (above_cur),
    .below_o   (below_cur)
  );

  elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan_nxt (
    .pending_i (pending_q),
    .floor_i   (next_floor),
    .above_o   (above_nxt),
    .below_o   (below_nxt)
  );

  assign req_ok       = req_valid && (int'(req_floor) < NUM_FLOORS);
  // A request for the open-door floor extends the stop instead of queuing.
  assign req_cur_door = req_ok && (state_q == ST_DOOR) && (req_floor == floor_q);
  assign set_vec      = (req_ok && !req_cur_door) ? floor_bit(req_floor) : '0;
  assign hit_cur      = |(pending_q & floor_bit(floor_q));
  // A request landing on the arrival edge still stops the car there.
  assign hit_next     = (|(pending_q & floor_bit(next_floor)))
                        || (req_ok && (req_floor == next_floor));
  assign going_up     = (state_q == ST_UP);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    floor_d  = floor_q;
    travel_d = travel_q;
    door_d   = door_q;
    clr_vec  = '0;

    unique case (state_q)
      ST_IDLE: begin
        travel_d = '0;
        door_d   = '0;
        if (hit_cur) begin
          state_d = ST_DOOR;
          clr_vec = floor_bit(floor_q);
        end else if (above_cur) begin
          state_d = ST_UP;
          dir_d   = DIR_UP;
        end else if (below_cur) begin
          state_d = ST_DOWN;
          dir_d   = DIR_DOWN;
        end
      end

      ST_UP, ST_DOWN: begin
        if (travel_q == TRAVEL_LAST) begin
          travel_d = '0;
          floor_d  = next_floor;
          if (hit_next) begin
            state_d = ST_DOOR;
            door_d  = '0;
            clr_vec = floor_bit(next_floor);
          end else if (going_up ? above_nxt : below_nxt) begin
            state_d = state_q;
          end else if (going_up ? below_nxt : above_nxt) begin
            state_d = going_up ? ST_DOWN : ST_UP;
            dir_d   = going_up ? DIR_DOWN : DIR_UP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          travel_d = travel_q + TRAVEL_W'(1);
        end
      end

      ST_DOOR: begin
        if (req_cur_door) begin
          door_d = '0;
        end else if (door_q == DOOR_LAST) begin
          door_d   = '0;
          travel_d = '0;
          // Keep the current scan direction when it still has work.
          if ((dir_q == DIR_UP) ? above_cur : below_cur) begin
            state_d = (dir_q == DIR_UP) ? ST_UP : ST_DOWN;
          end else if ((dir_q == DIR_UP) ? below_cur : above_cur) begin
            state_d = (dir_q == DIR_UP) ? ST_DOWN : ST_UP;
            dir_d   = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          door_d = door_q + DOOR_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Clear wins over a same-edge set of the same bit.
  assign pending_d = (pending_q | set_vec) & ~clr_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_UP;
      floor_q     <= '0;
      travel_q    <= '0;
      door_q      <= '0;
      pending_q   <= '0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      arrive_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q     <= state_d;
      dir_q       <= dir_d;
      floor_q     <= floor_d;
      travel_q    <= travel_d;
      door_q      <= door_d;
      pending_q   <= pending_d;
      moving_q    <= (state_d == ST_UP) || (state_d == ST_DOWN);
      door_open_q <= (state_d == ST_DOOR);
      arrive_q    <= (state_d == ST_DOOR) && (state_q != ST_DOOR);
    end
  end

  assign cur_floor = floor_q;
  assign dir_up    = (dir_q == DIR_UP);
  assign moving    = moving_q;
  assign door_open = door_open_q;
  assign arrive    = arrive_q;
  assign pending   = pending_q;

endmodule : elevator_scan_ctrl

// File: tb/tb_elevator_scan_ctrl.sv
// Self-checking bench for elevator_scan_ctrl.
// Instance dut_a uses default parameters; dut_b uses NUM_FLOORS = 5.
// Expected stops (floor, direction) are queued when requests are driven and
// popped by a monitor whenever dut_a pulses arrive.
module tb_elevator_scan_ctrl;

  typedef struct packed {
    logic [2:0] floor;
    logic       dir;
  } stop_t;

  logic       clk;
  logic       rst;

  logic       req_valid_a;
  logic [2:0] req_floor_a;
  logic [2:0] cur_floor_a;
  logic       dir_up_a, moving_a, door_open_a, arrive_a;
  logic [7:0] pending_a;

  logic       req_valid_b;
  logic [2:0] req_floor_b;
  logic [2:0] cur_floor_b;
  logic       dir_up_b, moving_b, door_open_b, arrive_b;
  logic [4:0] pending_b;

  stop_t sb[$];
  int    n_total = 0;
  int    n_pass  = 0;
  int    n_fail  = 0;
  logic  prev_arrive_a;

  elevator_scan_ctrl #(
    .NUM_FLOORS    (8),
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (8)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid_a),
    .req_floor (req_floor_a),
    .cur_floor (cur_floor_a),
    .dir_up    (dir_up_a),
    .moving    (moving_a),
    .door_open (door_open_a),
    .arrive    (arrive_a),
    .pending   (pending_a)
  );

  elevator_scan_ctrl #(
    .NUM_FLOORS    (5),
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (8)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid_b),
    .req_floor (req_floor_b),
    .cur_floor (cur_floor_b),
    .dir_up    (dir_up_b),
    .moving    (moving_b),
    .door_open (door_open_b),
    .arrive    (arrive_b),
    .pending   (pending_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_a(input int f);
    @(negedge clk);
    req_valid_a = 1'b1;
    req_floor_a = 3'(f);
    @(negedge clk);
    req_valid_a = 1'b0;
  endtask

  task automatic send_b(input int f);
    @(negedge clk);
    req_valid_b = 1'b1;
    req_floor_b = 3'(f);
    @(negedge clk);
    req_valid_b = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_floor_a(input string tag, input int f, input int budget);
    int cnt;
    cnt = 0;
    while (int'(cur_floor_a) != f && cnt < budget) begin
      tick(1);
      cnt++;
    end
    check(tag, 32'(int'(cur_floor_a) == f), 32'd1);
  endtask

  task automatic wait_door_a(input string tag, input int budget);
    int cnt;
    cnt = 0;
    while (!door_open_a && cnt < budget) begin
      tick(1);
      cnt++;
    end
    check(tag, 32'(door_open_a), 32'd1);
  endtask

  task automatic door_len_a(output int n);
    n = 0;
    while (door_open_a && n < 100) begin
      n++;
      tick(1);
    end
  endtask

  // Scoreboard consumer: every arrive must match the oldest expected stop.
  always @(negedge clk) begin
    if (rst) begin
      prev_arrive_a <= 1'b0;
    end else begin
      if (arrive_a) begin
        check("arrive_not_back_to_back", 32'(prev_arrive_a), 32'd0);
        check("arrive_with_door", 32'(door_open_a), 32'd1);
        check("arrive_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          stop_t e;
          e = sb.pop_front();
          check("stop_floor", 32'(cur_floor_a), 32'(e.floor));
          check("stop_dir", 32'(dir_up_a), 32'(e.dir));
        end
      end
      prev_arrive_a <= arrive_a;
    end
  end

  // The 5-floor car must never report a floor past its top.
  always @(negedge clk) begin
    if (!rst && moving_b) check("b_floor_in_range", 32'(cur_floor_b < 3'd5), 32'd1);
  end

  initial begin
    int n;
    rst         = 1'b1;
    req_valid_a = 1'b0;
    req_floor_a = '0;
    req_valid_b = 1'b0;
    req_floor_b = '0;

    // Reset values
    tick(2);
    check("rst_floor", 32'(cur_floor_a), 32'd0);
    check("rst_dir", 32'(dir_up_a), 32'd1);
    check("rst_moving", 32'(moving_a), 32'd0);
    check("rst_door", 32'(door_open_a), 32'd0);
    check("rst_arrive", 32'(arrive_a), 32'd0);
    check("rst_pending", 32'(pending_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);

    // Single request to floor 3: latency, per-floor timing, door length
    sb.push_back('{floor: 3'd3, dir: 1'b1});
    send_a(3);
    check("s1_pending_latched", 32'(pending_a), 32'h08);
    check("s1_idle_before_act", 32'(moving_a), 32'd0);
    tick(1);
    check("s1_moving", 32'(moving_a), 32'd1);
    tick(3);
    check("s1_floor0_t4", 32'(cur_floor_a), 32'd0);
    tick(1);
    check("s1_floor1_t5", 32'(cur_floor_a), 32'd1);
    tick(4);
    check("s1_floor2_t9", 32'(cur_floor_a), 32'd2);
    tick(4);
    check("s1_floor3_t13", 32'(cur_floor_a), 32'd3);
    check("s1_door_t13", 32'(door_open_a), 32'd1);
    door_len_a(n);
    check("s1_door_len", 32'(n), 32'd8);
    check("s1_idle_moving", 32'(moving_a), 32'd0);
    check("s1_idle_pending", 32'(pending_a), 32'd0);

    // Request 5, then 2 picked up on the way
    pulse_reset();
    sb.push_back('{floor: 3'd5, dir: 1'b1});
    send_a(5);
    wait_floor_a("s2_reach1", 1, 40);
    sb.push_front('{floor: 3'd2, dir: 1'b1});
    send_a(2);
    wait_door_a("s2_door_at2", 40);
    check("s2_floor2", 32'(cur_floor_a), 32'd2);
    door_len_a(n);
    check("s2_door2_len", 32'(n), 32'd8);
    check("s2_resume_moving", 32'(moving_a), 32'd1);
    check("s2_resume_dir", 32'(dir_up_a), 32'd1);
    wait_door_a("s2_door_at5", 60);
    check("s2_floor5", 32'(cur_floor_a), 32'd5);
    door_len_a(n);
    check("s2_door5_len", 32'(n), 32'd8);
    check("s2_pending_empty", 32'(pending_a), 32'd0);

    // Moving up toward 6, request 1: stop at 6, reverse, express to 1
    pulse_reset();
    sb.push_back('{floor: 3'd6, dir: 1'b1});
    send_a(6);
    wait_floor_a("s3_reach4", 4, 60);
    sb.push_back('{floor: 3'd1, dir: 1'b0});
    send_a(1);
    wait_door_a("s3_door_at6", 40);
    check("s3_floor6", 32'(cur_floor_a), 32'd6);
    door_len_a(n);
    check("s3_door6_len", 32'(n), 32'd8);
    check("s3_reverse_dir", 32'(dir_up_a), 32'd0);
    check("s3_reverse_moving", 32'(moving_a), 32'd1);
    n = 0;
    while (!door_open_a && n < 100) begin
      n++;
      tick(1);
    end
    check("s3_travel_6_to_1", 32'(n), 32'd20);
    check("s3_floor1", 32'(cur_floor_a), 32'd1);
    door_len_a(n);
    check("s3_door1_len", 32'(n), 32'd8);
    check("s3_pending_empty", 32'(pending_a), 32'd0);

    // Floor 2: same-edge request on arrival, then door extension at cycle 5
    sb.push_back('{floor: 3'd2, dir: 1'b1});
    send_a(2);
    tick(4);
    req_valid_a = 1'b1;
    req_floor_a = 3'd2;
    tick(1);
    req_valid_a = 1'b0;
    check("s4_arrive_door", 32'(door_open_a), 32'd1);
    check("s4_clear_wins", 32'(pending_a), 32'd0);
    n = 0;
    repeat (5) begin
      n++;
      tick(1);
    end
    req_valid_a = 1'b1;
    req_floor_a = 3'd2;
    n++;
    tick(1);
    req_valid_a = 1'b0;
    check("s4_ext_not_latched", 32'(pending_a), 32'd0);
    while (door_open_a && n < 100) begin
      n++;
      tick(1);
    end
    check("s4_door_extended_len", 32'(n), 32'd14);
    check("s4_idle", 32'(moving_a), 32'd0);

    // Five-floor instance: out-of-range request, then top floor
    send_b(7);
    check("s5_ignored_pending", 32'(pending_b), 32'd0);
    tick(2);
    check("s5_ignored_moving", 32'(moving_b), 32'd0);
    check("s5_ignored_door", 32'(door_open_b), 32'd0);
    send_b(4);
    n = 0;
    while (!door_open_b && n < 60) begin
      n++;
      tick(1);
    end
    check("s5_door_top", 32'(door_open_b), 32'd1);
    check("s5_floor_top", 32'(cur_floor_b), 32'd4);
    check("s5_arrive_top", 32'(arrive_b), 32'd1);
    tick(9);
    check("s5_idle_moving", 32'(moving_b), 32'd0);
    check("s5_idle_floor", 32'(cur_floor_b), 32'd4);
    check("s5_idle_pending", 32'(pending_b), 32'd0);

    // Reset while travelling between 2 and 3
    pulse_reset();
    send_a(5);
    send_a(7);
    wait_floor_a("s6_reach2", 2, 60);
    tick(2);
    check("s6_mid_moving", 32'(moving_a), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("s6_rst_floor", 32'(cur_floor_a), 32'd0);
    check("s6_rst_dir", 32'(dir_up_a), 32'd1);
    check("s6_rst_moving", 32'(moving_a), 32'd0);
    check("s6_rst_door", 32'(door_open_a), 32'd0);
    check("s6_rst_pending", 32'(pending_a), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(6);
    check("s6_post_floor", 32'(cur_floor_a), 32'd0);
    check("s6_post_moving", 32'(moving_a), 32'd0);
    check("s6_post_pending", 32'(pending_a), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_elevator_scan_ctrl
